// File: rtl/alu_cmd_issue_if.sv
// Handshake bundle for the ALU issue stage: command input, ALU drive/return and result port.
interface alu_cmd_issue_if #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) ();
  localparam int CW = $clog2(DEPTH + 1);

  logic                     cmd_valid;
  logic                     cmd_ready;
  logic [3:0]               cmd_opcode;
  logic signed [DATA_W-1:0] cmd_a;
  logic signed [DATA_W-1:0] cmd_b;
  logic                     cmd_cin;

  logic signed [DATA_W-1:0] alu_in1;
  logic signed [DATA_W-1:0] alu_in2;
  logic                     alu_cin;
  logic [3:0]               alu_opcode;
  logic [DATA_W-1:0]        alu_out;
  logic                     alu_cout;

  logic                     res_valid;
  logic                     res_ready;
  logic [DATA_W-1:0]        res_data;
  logic                     res_cout;
  logic                     res_zero;
  logic                     res_neg;
  logic                     res_err;
  logic [CW-1:0]            count;

  modport master (
    output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin, alu_out, alu_cout, res_ready,
    input  cmd_ready, alu_in1, alu_in2, alu_cin, alu_opcode,
    input  res_valid, res_data, res_cout, res_zero, res_neg, res_err, count
  );

  modport slave (
    input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin, alu_out, alu_cout, res_ready,
    output cmd_ready, alu_in1, alu_in2, alu_cin, alu_opcode,
    output res_valid, res_data, res_cout, res_zero, res_neg, res_err, count
  );
endinterface

// File: rtl/alu_cmd_issue.sv
// Issue stage for the 4-bit ALU: command FIFO, registered ALU drive, settle window,
// and a single-slot result register with zero/negative/illegal-opcode flags.
module alu_cmd_issue #(
  parameter int DEPTH  = 4,
  parameter int SETTLE = 1,
  parameter int DATA_W = 4
) (
  input logic           clk,
  input logic           rst,
  alu_cmd_issue_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = $clog2(DEPTH);
  localparam int SW = (SETTLE < 2) ? 1 : $clog2(SETTLE + 1);

  typedef struct packed {
    logic [3:0]               op;
    logic signed [DATA_W-1:0] a;
    logic signed [DATA_W-1:0] b;
    logic                     cin;
  } cmd_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              cout;
    logic              zero;
    logic              neg;
    logic              err;
  } res_t;

  typedef enum logic {IDLE, DRIVE} state_t;

  cmd_t          mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] cnt;
  state_t        state, state_nx;
  logic [SW-1:0] settle_cnt;
  logic          push, pop, cap;
  cmd_t          head;

  cmd_t          cmd_p0;
  logic          vld_p1;
  res_t          res_p1;

  function automatic logic op_legal(input logic [3:0] op);
    return op[3] || (op[3:1] == 3'b010);
  endfunction

  // Illegal opcodes are still issued, but their ALU response is masked to a clean error result.
  function automatic res_t shape_result(input logic [3:0] op, input logic [DATA_W-1:0] out,
                                        input logic cout);
    res_t r;
    r.err  = !op_legal(op);
    r.data = r.err ? '0 : out;
    r.cout = !r.err && cout;
    r.zero = !r.err && (out == '0);
    r.neg  = !r.err && out[DATA_W-1];
    return r;
  endfunction

  assign bus.cmd_ready = !rst && (cnt < CW'(DEPTH));
  assign push          = bus.cmd_valid && bus.cmd_ready;
  assign head          = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= '{bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_cin};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (pop) state_nx = DRIVE;
      DRIVE:   if (cap) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Issue only when the result slot is empty or being drained on this edge.
  always_comb begin
    pop = 1'b0;
    cap = 1'b0;
    case (state)
      IDLE:    pop = (cnt != '0) && (!vld_p1 || bus.res_ready);
      DRIVE:   cap = (settle_cnt == SW'(1));
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)                          settle_cnt <= '0;
    else if (pop)                     settle_cnt <= SW'(SETTLE);
    else if (state == DRIVE && !cap)  settle_cnt <= settle_cnt - SW'(1);
  end

  // ---- p0: registered ALU drive ----
  always_ff @(posedge clk) begin
    if (rst)      cmd_p0 <= '0;
    else if (pop) cmd_p0 <= head;
  end

  // ---- p1: captured result slot ----
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      res_p1 <= '0;
    end else if (cap) begin
      vld_p1 <= 1'b1;
      res_p1 <= shape_result(cmd_p0.op, bus.alu_out, bus.alu_cout);
    end else if (bus.res_ready) begin
      vld_p1 <= 1'b0;
    end
  end

  assign bus.alu_in1    = cmd_p0.a;
  assign bus.alu_in2    = cmd_p0.b;
  assign bus.alu_cin    = cmd_p0.cin;
  assign bus.alu_opcode = cmd_p0.op;
  assign bus.res_valid  = vld_p1;
  assign bus.res_data   = res_p1.data;
  assign bus.res_cout   = res_p1.cout;
  assign bus.res_zero   = res_p1.zero;
  assign bus.res_neg    = res_p1.neg;
  assign bus.res_err    = res_p1.err;
  assign bus.count      = cnt;
endmodule

// File: tb/tb_alu_cmd_issue.sv
// Self-checking bench for alu_cmd_issue: directed vector table, multi-cycle corner sequences,
// and randomized traffic scored against a queue-based reference with a behavioural ALU stub.
module tb_alu_cmd_issue;
  localparam int DEPTH  = 4;
  localparam int SETTLE = 1;
  localparam int DATA_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_cmd_issue_if #(.DEPTH(DEPTH), .DATA_W(DATA_W)) bus ();
  alu_cmd_issue #(.DEPTH(DEPTH), .SETTLE(SETTLE), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [3:0]        op;
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic              cin;
  } cmd_t;

  typedef struct {
    logic [3:0] data;
    logic       cout;
    logic       zero;
    logic       neg;
    logic       err;
  } exp_t;

  typedef struct {
    logic [3:0]        op;
    logic signed [3:0] a;
    logic signed [3:0] b;
    logic              cin;
    logic [3:0]        so;
    logic              sc;
    logic [3:0]        ed;
    logic              ec;
    logic              ez;
    logic              en;
    logic              ee;
  } vec_t;

  int   tests = 0;
  int   fails = 0;
  int   nres  = 0;
  int   npush = 0;
  exp_t q[$];

  logic       use_stub;
  logic [3:0] stub_out;
  logic       stub_cout;
  logic [4:0] model_r;

  // Behavioural stand-in for the downstream ALU: {cout, out}.
  function automatic logic [4:0] alu_fn(input logic [3:0] op, input logic [3:0] a,
                                        input logic [3:0] b, input logic cin);
    logic [4:0] r;
    case (op)
      4'b0100: r = {1'b0, a} + {1'b0, b} + {4'b0, cin};
      4'b0101: r = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
      4'b1000: r = {1'b0, ~a};
      4'b1001: r = {1'b0, a | b};
      4'b1010: r = {1'b0, a & b};
      4'b1011: r = {1'b0, a ^ b};
      4'b1100: r = {1'b0, a << b[1:0]};
      4'b1101: r = {1'b0, a >> b[1:0]};
      4'b1110: r = {1'b0, 4'($signed(a) >>> b[1:0])};
      4'b1111: r = {1'b0, a};
      default: r = 5'b11011;
    endcase
    return r;
  endfunction

  function automatic exp_t exp_of(input logic [3:0] op, input logic [3:0] a,
                                  input logic [3:0] b, input logic cin);
    exp_t       e;
    logic [4:0] r;
    r      = alu_fn(op, a, b, cin);
    e.err  = !(op inside {4'b0100, 4'b0101, [4'b1000:4'b1111]});
    e.data = e.err ? 4'b0000 : r[3:0];
    e.cout = e.err ? 1'b0 : r[4];
    e.zero = !e.err && (e.data == 4'b0000);
    e.neg  = !e.err && e.data[3];
    return e;
  endfunction

  assign model_r     = alu_fn(bus.alu_opcode, bus.alu_in1, bus.alu_in2, bus.alu_cin);
  assign bus.alu_out  = use_stub ? stub_out  : model_r[3:0];
  assign bus.alu_cout = use_stub ? stub_cout : model_r[4];

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_cmd(input cmd_t c);
    bus.cmd_opcode = c.op;
    bus.cmd_a      = c.a;
    bus.cmd_b      = c.b;
    bus.cmd_cin    = c.cin;
  endtask

  // Record accepted commands and score consumed results, then advance one clock.
  task automatic cycle();
    exp_t e;
    if (bus.cmd_valid && bus.cmd_ready) begin
      q.push_back(exp_of(bus.cmd_opcode, bus.cmd_a, bus.cmd_b, bus.cmd_cin));
      npush++;
    end
    if (bus.res_valid && bus.res_ready) begin
      nres++;
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL orphan_result: got data %0d with no command outstanding", bus.res_data);
      end else begin
        e = q.pop_front();
        chk("res_data", int'(bus.res_data), int'(e.data));
        chk("res_cout", int'(bus.res_cout), int'(e.cout));
        chk("res_zero", int'(bus.res_zero), int'(e.zero));
        chk("res_neg",  int'(bus.res_neg),  int'(e.neg));
        chk("res_err",  int'(bus.res_err),  int'(e.err));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vt[5];
    cmd_t c2[6];
    cmd_t rc;
    int   idx;
    logic acc;

    vt[0] = '{4'b0100, 4'sd2, 4'sd1, 1'b1, 4'b0100, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{4'b0000, 4'sd3, 4'sd5, 1'b0, 4'b1010, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};
    vt[2] = '{4'b1001, 4'sd1, 4'sd2, 1'b0, 4'b1000, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[3] = '{4'b0101, 4'sd4, 4'sd4, 1'b1, 4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[4] = '{4'b0111, 4'sd0, 4'sd0, 1'b0, 4'b0000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1};

    c2[0] = '{4'b0100, 4'sd3, -4'sd2, 1'b0};
    c2[1] = '{4'b1011, 4'sd5, 4'sd6, 1'b0};
    c2[2] = '{4'b1110, -4'sd8, 4'sd2, 1'b0};
    c2[3] = '{4'b0010, 4'sd1, 4'sd1, 1'b1};
    c2[4] = '{4'b0101, 4'sd2, 4'sd2, 1'b1};
    c2[5] = '{4'b1000, 4'sd7, 4'sd0, 1'b0};

    rst = 1'b1;
    use_stub = 1'b1;
    stub_out = 4'b0;
    stub_cout = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_opcode = 4'b0;
    bus.cmd_a = 4'sd0;
    bus.cmd_b = 4'sd0;
    bus.cmd_cin = 1'b0;
    bus.res_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("ready_in_reset", int'(bus.cmd_ready), 0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_cmd_ready",  int'(bus.cmd_ready), 1);
    chk("rst_count",      int'(bus.count), 0);
    chk("rst_res_valid",  int'(bus.res_valid), 0);
    chk("rst_alu_in1",    int'(bus.alu_in1), 0);
    chk("rst_alu_opcode", int'(bus.alu_opcode), 0);
    chk("rst_res_data",   int'(bus.res_data), 0);
    chk("rst_res_err",    int'(bus.res_err), 0);

    // Directed vectors with a stubbed ALU response: latency, drive values and flags.
    for (int i = 0; i < 5; i++) begin
      stub_out = vt[i].so;
      stub_cout = vt[i].sc;
      bus.cmd_opcode = vt[i].op;
      bus.cmd_a = vt[i].a;
      bus.cmd_b = vt[i].b;
      bus.cmd_cin = vt[i].cin;
      bus.cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      chk("v_count_after_push", int'(bus.count), 1);
      chk("v_early_valid_T",    int'(bus.res_valid), 0);
      @(posedge clk);
      #1;
      chk("v_alu_in1",    int'(bus.alu_in1), int'(vt[i].a));
      chk("v_alu_in2",    int'(bus.alu_in2), int'(vt[i].b));
      chk("v_alu_cin",    int'(bus.alu_cin), int'(vt[i].cin));
      chk("v_alu_opcode", int'(bus.alu_opcode), int'(vt[i].op));
      chk("v_early_valid_T1", int'(bus.res_valid), 0);
      chk("v_count_after_pop", int'(bus.count), 0);
      @(posedge clk);
      #1;
      chk("v_res_valid", int'(bus.res_valid), 1);
      chk("v_res_data",  int'(bus.res_data), int'(vt[i].ed));
      chk("v_res_cout",  int'(bus.res_cout), int'(vt[i].ec));
      chk("v_res_zero",  int'(bus.res_zero), int'(vt[i].ez));
      chk("v_res_neg",   int'(bus.res_neg),  int'(vt[i].en));
      chk("v_res_err",   int'(bus.res_err),  int'(vt[i].ee));
      bus.res_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.res_ready = 1'b0;
      chk("v_res_cleared", int'(bus.res_valid), 0);
    end

    // Back-pressure: six offers with the result slot blocked, then a long stall, then drain.
    use_stub = 1'b0;
    nres = 0;
    idx = 0;
    bus.res_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (idx < 6) begin
        set_cmd(c2[idx]);
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      cycle();
      if (acc) idx++;
    end
    chk("bp_count_full",  int'(bus.count), 4);
    chk("bp_cmd_ready",   int'(bus.cmd_ready), 0);
    chk("bp_res_valid",   int'(bus.res_valid), 1);
    chk("bp_accepted",    idx, 5);
    for (int k = 0; k < 10; k++) begin
      chk("stall_res_data", int'(bus.res_data), int'(q[0].data));
      chk("stall_res_err",  int'(bus.res_err),  int'(q[0].err));
      chk("stall_alu_in1",  int'(bus.alu_in1),  int'(c2[0].a));
      chk("stall_alu_op",   int'(bus.alu_opcode), int'(c2[0].op));
      chk("stall_count",    int'(bus.count), 4);
      cycle();
    end
    bus.res_ready = 1'b1;
    for (int k = 0; k < 80; k++) begin
      if (idx < 6) begin
        set_cmd(c2[idx]);
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      cycle();
      if (acc) idx++;
      if (idx == 6 && q.size() == 0 && !bus.res_valid) break;
    end
    bus.cmd_valid = 1'b0;
    chk("bp_all_pushed",   idx, 6);
    chk("bp_queue_empty",  q.size(), 0);
    chk("bp_results_seen", nres, 6);

    // Reset while an op is being driven with three more queued.
    bus.res_ready = 1'b0;
    idx = 0;
    for (int k = 0; k < 6; k++) begin
      if (idx < 5) begin
        set_cmd(c2[idx]);
        bus.cmd_valid = 1'b1;
      end else begin
        bus.cmd_valid = 1'b0;
      end
      acc = bus.cmd_valid && bus.cmd_ready;
      cycle();
      if (acc) idx++;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    cycle();
    chk("pre_rst_alu_in1", int'(bus.alu_in1), int'(c2[1].a));
    chk("pre_rst_count",   int'(bus.count), 3);
    rst = 1'b1;
    bus.res_ready = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_rst_count",     int'(bus.count), 0);
    chk("mid_rst_res_valid", int'(bus.res_valid), 0);
    chk("mid_rst_cmd_ready", int'(bus.cmd_ready), 0);
    chk("mid_rst_alu_in1",   int'(bus.alu_in1), 0);
    chk("mid_rst_alu_in2",   int'(bus.alu_in2), 0);
    chk("mid_rst_alu_op",    int'(bus.alu_opcode), 0);
    chk("mid_rst_res_data",  int'(bus.res_data), 0);
    rst = 1'b0;
    q.delete();
    bus.res_ready = 1'b1;
    for (int k = 0; k < 5; k++) cycle();
    chk("post_rst_no_result", int'(bus.res_valid), 0);
    chk("post_rst_count",     int'(bus.count), 0);

    // Randomized traffic against the queue reference.
    nres = 0;
    npush = 0;
    for (int k = 0; k < 500; k++) begin
      if (!bus.cmd_valid && ($urandom_range(0, 99) < 60)) begin
        rc.op  = 4'($urandom_range(0, 15));
        rc.a   = 4'($urandom_range(0, 15));
        rc.b   = 4'($urandom_range(0, 15));
        rc.cin = 1'($urandom_range(0, 1));
        set_cmd(rc);
        bus.cmd_valid = 1'b1;
      end
      bus.res_ready = ($urandom_range(0, 99) < 50);
      acc = bus.cmd_valid && bus.cmd_ready;
      cycle();
      if (acc) bus.cmd_valid = 1'b0;
    end
    bus.cmd_valid = 1'b0;
    bus.res_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      if (q.size() == 0 && !bus.res_valid) break;
      cycle();
    end
    chk("rand_queue_empty", q.size(), 0);
    chk("rand_push_vs_res", nres, npush);
    chk("rand_final_count", int'(bus.count), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
